// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset PC and FSM state encodings.
package if_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INS      = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP      = 32'h0000_0004;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    // Force a target address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// hands an instruction/return-address pair to IF/ID and inserts NOP bubbles.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ins,
    output logic [31:0] IF_ra,
    output logic        fetch_wait
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic [31:0]  ins_buf_q, ins_buf_d;

    logic [31:0]  pc_inc;
    logic [31:0]  redirect_tgt;

    // Inline PC incrementer (wraps modulo 2^32) and aligned redirect target.
    assign pc_inc       = pc_q + PC_STEP;
    assign redirect_tgt = word_align(redirect_pc);

    // Memory address and return address follow the PC directly.
    assign imem_addr = pc_q;
    assign IF_ra     = pc_inc;

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0000_0000;
            ins_buf_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            ins_buf_q    <= ins_buf_d;
        end
    end

    // Next-state, next-PC mux and IF/ID-facing outputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        ins_buf_d    = ins_buf_q;
        imem_req     = 1'b0;
        IF_ins       = NOP_INS;
        fetch_wait   = 1'b1;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (!imem_ack) begin
                    // Request cannot be cancelled; remember the latest redirect.
                    if (redirect_valid) begin
                        redir_pc_d   = redirect_tgt;
                        redir_pend_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d         = redirect_tgt;
                    redir_pend_d = 1'b0;
                end else if (redir_pend_q) begin
                    pc_d         = redir_pc_q;
                    redir_pend_d = 1'b0;
                end else begin
                    IF_ins     = imem_rdata;
                    fetch_wait = 1'b0;
                    if (stall) begin
                        ins_buf_d = imem_rdata;
                        state_d   = S_HOLD;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end

            S_HOLD: begin
                IF_ins     = ins_buf_q;
                fetch_wait = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

endmodule
